// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch stage
//
// Purpose: default instruction-memory geometry, the reset fetch address,
//          the word-index width and the fetch FSM state encoding.
// Contents: IMEM_DEPTH_DEF, RESET_PC_DEF, PC_W, state_t {ST_BOOT, ST_RUN, ST_HALTED}.

package cpu_pkg;

   localparam int          PC_W           = 32;
   localparam int          IMEM_DEPTH_DEF = 128;
   localparam logic [31:0] RESET_PC_DEF   = 32'd0;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and fetch control ahead of a synchronous instruction memory
//
// Purpose: drives the memory word index every cycle, tracks which word the
//          memory is currently presenting, qualifies it for decode, and handles
//          stall, redirect with wrong-path squash, wrap at memory depth and halt.
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   stall          in   decode cannot take the current instruction
//   redirect_valid in   execute resolved a taken branch/jump
//   redirect_pc    in   [31:0] redirect target word index
//   halt_req       in   stop fetching until reset
//   pc             out  [31:0] word index to instruction memory
//   fetch_pc       out  [31:0] word index of the instruction on the memory output
//   fetch_valid    out  memory output is a valid, non-squashed instruction
//   halted         out  unit is halted
//   instr_count    out  [31:0] instructions consumed by decode

module fetch_pc_unit
   import cpu_pkg::*;
#(
   parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt_req,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] fetch_pc,
   output logic            fetch_valid,
   output logic            halted,
   output logic [PC_W-1:0] instr_count
);

   localparam logic [PC_W-1:0] PC_MASK = PC_W'(IMEM_DEPTH - 1);

   // Wrap-around increment; IMEM_DEPTH is a power of two so masking wraps.
   function automatic logic [PC_W-1:0] inc_pc(input logic [PC_W-1:0] x);
      return (x + 32'd1) & PC_MASK;
   endfunction

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_fetch_pc;
   logic            r_fetch_valid;
   logic [PC_W-1:0] r_instr_count;

   state_t          w_state_nxt;
   logic [PC_W-1:0] w_pc_nxt;
   logic [PC_W-1:0] w_fetch_pc_nxt;
   logic            w_fetch_valid_nxt;
   logic [PC_W-1:0] w_instr_count_nxt;
   logic            w_hold_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_fetch_pc    <= RESET_PC;
         r_fetch_valid <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_fetch_pc    <= w_fetch_pc_nxt;
         r_fetch_valid <= w_fetch_valid_nxt;
         r_instr_count <= w_instr_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_fetch_pc_nxt    = r_fetch_pc;
      w_fetch_valid_nxt = r_fetch_valid;
      w_instr_count_nxt = r_instr_count;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt       = ST_RUN;
            w_fetch_pc_nxt    = r_pc;
            w_fetch_valid_nxt = 1'b1;
            w_pc_nxt          = inc_pc(r_pc);
         end
         ST_RUN: begin
            if (halt_req) begin
               w_state_nxt       = ST_HALTED;
               w_fetch_valid_nxt = 1'b0;
            end else if (redirect_valid) begin
               // The word latched at this edge is on the wrong path: squash it.
               w_pc_nxt          = redirect_pc & PC_MASK;
               w_fetch_pc_nxt    = r_pc;
               w_fetch_valid_nxt = 1'b0;
            end else if (!stall) begin
               if (r_fetch_valid) begin
                  w_instr_count_nxt = r_instr_count + 32'd1;
               end
               w_fetch_pc_nxt    = r_pc;
               w_fetch_valid_nxt = 1'b1;
               w_pc_nxt          = inc_pc(r_pc);
            end
         end
         ST_HALTED: begin
            w_fetch_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   // During a stall the memory must re-read the word it is presenting,
   // since it has no enable and would otherwise move on.
   assign w_hold_addr = (r_state == ST_RUN) && stall && !redirect_valid;

   assign pc          = w_hold_addr ? r_fetch_pc : r_pc;
   assign fetch_pc    = r_fetch_pc;
   assign fetch_valid = r_fetch_valid;
   assign halted      = (r_state == ST_HALTED);
   assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit

module tb_fetch_pc_unit;

   localparam int DEPTH = 128;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        halted;
   logic [31:0] instr_count;

   fetch_pc_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .pc             (pc),
      .fetch_pc       (fetch_pc),
      .fetch_valid    (fetch_valid),
      .halted         (halted),
      .instr_count    (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: what the fetch stage must present, from the rules.
   bit          m_booting;
   bit          m_halted;
   bit          m_valid;
   int unsigned m_next;
   int unsigned m_fpc;
   int unsigned m_cnt;

   initial begin
      m_booting = 1; m_halted = 0; m_valid = 0; m_next = 0; m_fpc = 0; m_cnt = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_booting = 1; m_halted = 0; m_valid = 0; m_next = 0; m_fpc = 0; m_cnt = 0;
         end else if (m_halted) begin
            m_valid = 0;
         end else if (m_booting) begin
            m_booting = 0;
            m_fpc = m_next; m_next = (m_next + 1) % DEPTH; m_valid = 1;
         end else if (halt_req) begin
            m_halted = 1; m_valid = 0;
         end else if (redirect_valid) begin
            m_fpc = m_next; m_next = redirect_pc % DEPTH; m_valid = 0;
         end else if (!stall) begin
            if (m_valid) m_cnt = m_cnt + 1;
            m_fpc = m_next; m_next = (m_next + 1) % DEPTH; m_valid = 1;
         end
      end
   end

   function automatic logic [31:0] model_pc();
      if (!m_booting && !m_halted && stall && !redirect_valid) return m_fpc;
      return m_next;
   endfunction

   always @(negedge clk) begin
      chk("cyc_pc",          pc,                 model_pc());
      chk("cyc_fetch_pc",    fetch_pc,           m_fpc);
      chk("cyc_fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
      chk("cyc_halted",      {31'd0, halted},      {31'd0, m_halted});
      chk("cyc_instr_count", instr_count,        m_cnt);
   end

   task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic h);
      stall = s; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_fpc,
                             input logic e_v, input logic [31:0] e_cnt);
      chk({tag, "_pc"},    pc,       e_pc);
      chk({tag, "_fpc"},   fetch_pc, e_fpc);
      chk({tag, "_valid"}, {31'd0, fetch_valid}, {31'd0, e_v});
      chk({tag, "_count"}, instr_count, e_cnt);
   endtask

   task automatic do_reset();
      stall = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Reset release with no stall: boot cycle then sequential fetch.
   task automatic boot_seq(input string tag);
      expect_out({tag, "0"}, 0, 0, 0, 0);
      chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
      step(0, 0, 0, 0); expect_out({tag, "1"}, 1, 0, 1, 0);
      step(0, 0, 0, 0); expect_out({tag, "2"}, 2, 1, 1, 1);
      step(0, 0, 0, 0); expect_out({tag, "3"}, 3, 2, 1, 2);
   endtask

   logic [31:0] frozen_pc;
   logic [31:0] frozen_fpc;

   initial begin
      rst_n = 1'b0;
      do_reset();
      boot_seq("boot");

      // Stall for three cycles while word 5 is on the memory output.
      repeat (3) step(0, 0, 0, 0);
      stall = 1; #1;
      chk("stall_pc_comb", pc, 32'd5);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         expect_out("stall", 5, 5, 1, 5);
      end
      step(0, 0, 0, 0); expect_out("unstall", 7, 6, 1, 6);

      // Redirect to 40 while word 10 is presented; 10 must not be counted.
      repeat (4) step(0, 0, 0, 0);
      chk("pre_redir_fpc", fetch_pc, 32'd10);
      step(0, 1, 32'd40, 0); expect_out("redir_bubble", 40, 11, 0, 10);
      step(0, 0, 0, 0);      expect_out("redir_target", 41, 40, 1, 10);
      step(0, 0, 0, 0);      expect_out("redir_next", 42, 41, 1, 11);

      // Wrap at the top of memory.
      step(0, 1, 32'd126, 0);
      step(0, 0, 0, 0); chk("wrap_126", fetch_pc, 32'd126);
      step(0, 0, 0, 0); chk("wrap_127", fetch_pc, 32'd127);
      step(0, 0, 0, 0); chk("wrap_0",   fetch_pc, 32'd0);
      step(0, 0, 0, 0); chk("wrap_1",   fetch_pc, 32'd1);
      chk("wrap_pc", pc, 32'd2);

      // Out-of-range redirect target is masked: 200 mod 128 = 72.
      step(0, 1, 32'd200, 0);
      step(0, 0, 0, 0); chk("mask_72", fetch_pc, 32'd72);

      // Halt wins over redirect and stall, then everything is ignored.
      step(1, 1, 32'd7, 1);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_valid",  {31'd0, fetch_valid}, 32'd0);
      frozen_pc = pc;
      frozen_fpc = fetch_pc;
      for (int i = 0; i < 10; i++) begin
         step(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
         chk("halted_hold",   {31'd0, halted}, 32'd1);
         chk("halted_valid",  {31'd0, fetch_valid}, 32'd0);
         chk("halted_pc",     pc, frozen_pc);
         chk("halted_fpc",    fetch_pc, frozen_fpc);
      end
      do_reset();
      boot_seq("rehalt");

      // Randomised run checked cycle-by-cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom, 1'b0);
      end

      // Asynchronous reset between edges while stalled.
      stall = 1; redirect_valid = 0; halt_req = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 0, 0, 0);
      chk("async_rst_halted", {31'd0, halted}, 32'd0);
      stall = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      boot_seq("recover");

      // Randomised run including occasional halt.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
              $urandom_range(0, 99) == 0);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
